// File: rtl/down_counter_timer.sv
// Loadable down-counting timer with one-shot / auto-reload modes, pause and abort.
// Q decrements once per clk in RUN; a registered one-cycle expired pulse marks the zero crossing.
module down_counter_timer #(
  parameter int WIDTH        = 8,
  parameter int DEFAULT_LOAD = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             periodic,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             ready,
  output logic             expired
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             periodic_q, periodic_d;
  logic             busy_q, busy_d;
  logic             expired_q, expired_d;
  logic [WIDTH-1:0] load_eff;

  // A zero load would expire immediately, so it is replaced by the default period.
  assign load_eff = (load_val == '0) ? WIDTH'(DEFAULT_LOAD) : load_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      q_q        <= '0;
      reload_q   <= '0;
      periodic_q <= 1'b0;
      busy_q     <= 1'b0;
      expired_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      q_q        <= q_d;
      reload_q   <= reload_d;
      periodic_q <= periodic_d;
      busy_q     <= busy_d;
      expired_q  <= expired_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    q_d        = q_q;
    reload_d   = reload_q;
    periodic_d = periodic_q;
    busy_d     = busy_q;
    expired_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          q_d        = load_eff;
          reload_d   = load_eff;
          periodic_d = periodic;
          state_d    = RUN;
          busy_d     = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          q_d     = '0;
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (pause) begin
          state_d = HOLD;
        end else if (q_q != '0) begin
          q_d = q_q - WIDTH'(1);
        end else begin
          expired_d = 1'b1;
          if (periodic_q) begin
            q_d = reload_q;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      HOLD: begin
        // Leaving HOLD costs one cycle; counting restarts on the cycle after that.
        if (abort) begin
          q_d     = '0;
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (!pause) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        q_d     = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign Q       = q_q;
  assign busy    = busy_q;
  assign ready   = ~busy_q;
  assign expired = expired_q;

  // Once running with a non-zero count, Q can only hold, decrement or clear.
  a_no_increment: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != IDLE && q_q != '0) |=> (q_q <= $past(q_q)));

  a_expired_cause: assert property (@(posedge clk) disable iff (!rst_n)
    expired_q |-> ($past(q_q) == '0 && !$past(abort) && !$past(pause)));

  a_busy_state: assert property (@(posedge clk) disable iff (!rst_n)
    busy_q == (state_q != IDLE));

  c_periodic_reload: cover property (@(posedge clk) disable iff (!rst_n)
    (busy_q && periodic_q && q_q == '0) ##1 (q_q == reload_q));

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer: reset, one-shot, periodic, default load, pause and edge cases.
module tb_down_counter_timer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] load_val;
  logic       periodic;
  logic       pause;
  logic       abort;
  logic [7:0] Q;
  logic       busy;
  logic       ready;
  logic       expired;

  int checks = 0;
  int errors = 0;
  int n;

  down_counter_timer #(.WIDTH(8), .DEFAULT_LOAD(128)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .load_val (load_val),
    .periodic (periodic),
    .pause    (pause),
    .abort    (abort),
    .Q        (Q),
    .busy     (busy),
    .ready    (ready),
    .expired  (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-14s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; load_val = 8'd0; periodic = 1'b0; pause = 1'b0; abort = 1'b0;
    #12;
    chk("rst_q", Q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ready, 1);
    chk("rst_exp", expired, 0);
    rst_n = 1'b1;
    step();

    // One-shot, load 3: Q = 3,2,1,0 then expired with busy dropping.
    start = 1'b1; load_val = 8'd3; periodic = 1'b0;
    step();
    start = 1'b0;
    chk("os_q3", Q, 3);
    chk("os_busy", busy, 1);
    chk("os_ready", ready, 0);
    step(); chk("os_q2", Q, 2);
    step(); chk("os_q1", Q, 1);
    step(); chk("os_q0", Q, 0);
    chk("os_noexp", expired, 0);
    step();
    chk("os_exp", expired, 1);
    chk("os_busy_drop", busy, 0);
    chk("os_q_stay0", Q, 0);
    chk("os_ready_exp", ready, 1);

    // Start on the cycle right after the one-shot expiry is accepted.
    start = 1'b1; load_val = 8'd1;
    step();
    start = 1'b0;
    chk("post_exp_q", Q, 1);
    chk("post_exp_busy", busy, 1);
    chk("post_exp_pulse", expired, 0);
    step(); chk("post_exp_q0", Q, 0);
    step(); chk("post_exp_exp", expired, 1);
    step(); chk("exp_one_cycle", expired, 0);

    // Asynchronous reset mid-count at Q = 5, observed before any clock edge.
    start = 1'b1; load_val = 8'd9;
    step();
    start = 1'b0;
    repeat (4) step();
    chk("pre_rst_q", Q, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_q", Q, 0);
    chk("arst_busy", busy, 0);
    chk("arst_exp", expired, 0);
    rst_n = 1'b1;
    step();
    chk("arst_idle", busy, 0);

    // Periodic, load 2: 2,1,0,2,1,0 with a pulse every 3 cycles.
    start = 1'b1; load_val = 8'd2; periodic = 1'b1;
    step();
    start = 1'b0; periodic = 1'b0;
    chk("per_q2a", Q, 2);
    step(); chk("per_q1a", Q, 1);
    step(); chk("per_q0a", Q, 0);
    step();
    chk("per_reload", Q, 2);
    chk("per_exp1", expired, 1);
    chk("per_busy", busy, 1);
    step(); chk("per_q1b", Q, 1); chk("per_noexp", expired, 0);
    step(); chk("per_q0b", Q, 0);
    step(); chk("per_exp2", expired, 1); chk("per_q2c", Q, 2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_q", Q, 0);
    chk("abort_busy", busy, 0);
    chk("abort_noexp", expired, 0);
    step(); chk("abort_noexp2", expired, 0);

    // load_val = 0 loads 128; expired follows 129 cycles after Q shows 128.
    start = 1'b1; load_val = 8'd0;
    step();
    start = 1'b0;
    chk("dflt_q", Q, 128);
    n = 0;
    while (!expired && n < 300) begin
      step();
      n++;
    end
    chk("dflt_latency", n, 129);

    // Load 10 normally expires 11 cycles after Q = 10. Pause over 3 edges at Q = 7
    // freezes Q for 3 HOLD cycles plus the resume cycle: expiry moves by 4.
    step();
    start = 1'b1; load_val = 8'd10;
    step();
    start = 1'b0;
    n = 0;
    repeat (3) begin step(); n++; end
    chk("pz_q7", Q, 7);
    pause = 1'b1;
    step(); n++; chk("pz_hold1", Q, 7);
    step(); n++; chk("pz_hold2", Q, 7);
    step(); n++; chk("pz_hold3", Q, 7);
    chk("pz_busy", busy, 1);
    pause = 1'b0;
    step(); n++; chk("pz_resume", Q, 7);
    step(); n++; chk("pz_q6", Q, 6);
    while (!expired && n < 100) begin
      step();
      n++;
    end
    chk("pz_latency", n, 15);

    // start while busy is ignored; start with abort lands in IDLE with start dropped.
    step();
    start = 1'b1; load_val = 8'd5;
    step();
    chk("busy_q5", Q, 5);
    load_val = 8'd50;
    step();
    chk("busy_start_ign", Q, 4);
    abort = 1'b1; load_val = 8'd20;
    step();
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", busy, 0);
    chk("sa_q", Q, 0);
    chk("sa_ready", ready, 1);
    step();
    chk("sa_dropped", busy, 0);
    chk("sa_q_after", Q, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
